// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct encodings,
// FSM states, ALU operation encoding and default memory-map addresses.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_IO_OUT_ADDR = 32'h1001_0024;
    localparam logic [31:0] DEFAULT_IO_IN_ADDR  = 32'h1001_0028;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } stateT;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } aluOpT;

    function automatic logic [31:0] signExtend(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic isLegalInstr(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL};
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic aluOpT decodeAluOp(input logic [5:0] op, input logic [5:0] funct);
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  return ALU_SUB;
                FN_AND:  return ALU_AND;
                FN_OR:   return ALU_OR;
                FN_NOR:  return ALU_NOR;
                FN_SLL:  return ALU_SLL;
                FN_SRL:  return ALU_SRL;
                default: return ALU_ADD;
            endcase
        end
        case (op)
            OP_ORI:  return ALU_OR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, register $0 hardwired to zero.
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  readAddrA,
    input  logic [4:0]  readAddrB,
    output logic [31:0] readDataA,
    output logic [31:0] readDataB,
    input  logic        writeEnable,
    input  logic [4:0]  writeAddr,
    input  logic [31:0] writeData
);

    logic [31:0] regs [32];

    // NOTE: the array is cleared by reset because software may rely on all
    // registers starting at zero; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEnable && (writeAddr != 5'd0)) begin
            // NOTE: sequential state always uses <= so every flop samples pre-edge values.
            regs[writeAddr] <= writeData;
        end
    end

    assign readDataA = (readAddrA == 5'd0) ? 32'h0 : regs[readAddrA];
    assign readDataB = (readAddrB == 5'd0) ? 32'h0 : regs[readAddrB];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FSM-sequenced datapath sharing one req/ready memory
// port for fetch and data, with memory-mapped I/O, illegal-op trap and retire counter.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 32,
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter logic [31:0] IO_OUT_ADDR   = DEFAULT_IO_OUT_ADDR,
    parameter logic [31:0] IO_IN_ADDR    = DEFAULT_IO_IN_ADDR,
    parameter int          PORT_IN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ready,
    input  logic [PORT_IN_WIDTH-1:0] port_in,
    output logic [31:0]              port_out,
    output logic [31:0]              alu_result_out,
    output logic [31:0]              pc_out,
    output logic [31:0]              instr_count,
    output logic                     trap
);

    stateT       state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [31:0] mdr;
    logic [31:0] aluOut;
    logic [31:0] portOut;
    logic [31:0] instrCount;
    logic        trapFlag;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] immSext;
    logic [31:0] immZext;
    logic [31:0] branchOffset;
    logic [31:0] jumpTarget;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign shamt        = ir[10:6];
    assign funct        = ir[5:0];
    assign imm          = ir[15:0];
    assign immSext      = signExtend(imm);
    assign immZext      = {16'h0, imm};
    assign branchOffset = {immSext[29:0], 2'b00};
    // PC has already advanced past the jump, matching MIPS region semantics.
    assign jumpTarget   = {pc[31:28], ir[25:0], 2'b00};

    logic  isRType;
    logic  isLw;
    logic  isSw;
    logic  isBranch;
    logic  legal;
    logic  branchTaken;
    logic  ioAccess;
    aluOpT aluOp;

    assign isRType     = (opcode == OP_RTYPE);
    assign isLw        = (opcode == OP_LW);
    assign isSw        = (opcode == OP_SW);
    assign isBranch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign legal       = isLegalInstr(opcode, funct);
    assign aluOp       = decodeAluOp(opcode, funct);
    assign branchTaken = (opcode == OP_BNE) ? (regA != regB) : (regA == regB);
    // Only the matching direction is an I/O access; the other direction goes to the bus.
    assign ioAccess    = (isSw && (aluOut == IO_OUT_ADDR)) || (isLw && (aluOut == IO_IN_ADDR));

    logic [31:0] aluB;
    logic [31:0] aluResult;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        aluB      = isRType ? regB : ((opcode == OP_ORI) ? immZext : immSext);
        aluResult = '0;
        case (aluOp)
            ALU_ADD: aluResult = regA + aluB;
            ALU_SUB: aluResult = regA - aluB;
            ALU_AND: aluResult = regA & aluB;
            ALU_OR:  aluResult = regA | aluB;
            ALU_NOR: aluResult = ~(regA | aluB);
            ALU_SLL: aluResult = regB << shamt;
            ALU_SRL: aluResult = regB >> shamt;
            ALU_LUI: aluResult = {imm, 16'h0};
            default: aluResult = '0;
        endcase
    end

    logic [31:0] rfReadA;
    logic [31:0] rfReadB;
    logic [4:0]  rfWriteAddr;
    logic [31:0] rfWriteData;
    logic        rfWriteEnable;

    assign rfWriteEnable = (state == S_WRITEBACK);
    assign rfWriteAddr   = isRType ? rd : rt;
    assign rfWriteData   = isLw ? mdr : aluOut;

    mips_regfile regFile (
        .clk         (clk),
        .reset       (reset),
        .readAddrA   (rs),
        .readAddrB   (rt),
        .readDataA   (rfReadA),
        .readDataB   (rfReadB),
        .writeEnable (rfWriteEnable),
        .writeAddr   (rfWriteAddr),
        .writeData   (rfWriteData)
    );

    logic        memDone;
    logic [31:0] busAddr;

    assign memDone = ioAccess || mem_ready;
    assign busAddr = (state == S_MEMORY) ? aluOut : pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            regA       <= '0;
            regB       <= '0;
            mdr        <= '0;
            aluOut     <= '0;
            portOut    <= '0;
            instrCount <= '0;
            trapFlag   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    regA   <= rfReadA;
                    regB   <= rfReadB;
                    aluOut <= pc + branchOffset;
                    if (!legal) begin
                        trapFlag <= 1'b1;
                        state    <= S_TRAP;
                    end else if (opcode == OP_J) begin
                        pc         <= jumpTarget;
                        instrCount <= instrCount + 32'd1;
                        state      <= S_FETCH;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (isBranch) begin
                        if (branchTaken) begin
                            pc <= aluOut;
                        end
                        instrCount <= instrCount + 32'd1;
                        state      <= S_FETCH;
                    end else begin
                        aluOut <= aluResult;
                        state  <= (isLw || isSw) ? S_MEMORY : S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (memDone) begin
                        if (isSw) begin
                            if (ioAccess) begin
                                portOut <= regB;
                            end
                            instrCount <= instrCount + 32'd1;
                            state      <= S_FETCH;
                        end else begin
                            mdr   <= ioAccess ? 32'(port_in) : mem_rdata;
                            state <= S_WRITEBACK;
                        end
                    end
                end
                S_WRITEBACK: begin
                    instrCount <= instrCount + 32'd1;
                    state      <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Bus controls decode straight from state so a request and its ready can
    // share a cycle; gating with reset drops the request the instant reset asserts.
    assign mem_req   = reset && ((state == S_FETCH) || ((state == S_MEMORY) && !ioAccess));
    assign mem_we    = (state == S_MEMORY) && isSw && !ioAccess;
    assign mem_addr  = busAddr[ADDR_WIDTH-1:0];
    assign mem_wdata = regB;

    assign port_out       = portOut;
    assign alu_result_out = aluOut;
    assign pc_out         = pc;
    assign instr_count    = instrCount;
    assign trap           = trapFlag;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench: random-stall memory responder plus an instruction-level
// reference model that predicts registers, PC, port_out, retire count and cycles.
module tb_mips_multicycle_core;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] IO_OUT   = 32'h1001_0024;
    localparam logic [31:0] IO_IN    = 32'h1001_0028;
    localparam logic [31:0] RAM_BASE = 32'h1001_0000;

    localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27, FN_SLL = 6'h00, FN_SRL = 6'h02;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
    logic [7:0]  portIn = 8'h00;
    logic [31:0] port_out, alu_result_out, pc_out, instr_count;
    logic        trap;

    always #5 clk = ~clk;

    mips_multicycle_core dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .port_in        (portIn),
        .port_out       (port_out),
        .alu_result_out (alu_result_out),
        .pc_out         (pc_out),
        .instr_count    (instr_count),
        .trap           (trap)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] ram    [logic [31:0]];
    logic [31:0] refMem [logic [31:0]];
    logic [31:0] prog   [$];

    // Memory responder: random ready latency per request, stability check while stalled.
    int          maxStall = 0;
    int          stallLeft = 0;
    bit          busy = 0;
    int          ioBusHits = 0;
    logic [31:0] reqAddr, reqWdata;
    logic        reqWe;

    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ready = 1'b0;
            busy      = 0;
        end else begin
            if (!busy) begin
                busy      = 1;
                stallLeft = int'($urandom_range(0, maxStall));
                reqAddr   = mem_addr;
                reqWe     = mem_we;
                reqWdata  = mem_wdata;
                if ((mem_we && mem_addr == IO_OUT) || (!mem_we && mem_addr == IO_IN)) ioBusHits++;
            end else begin
                check("bus_addr_stable", mem_addr, reqAddr);
                check("bus_we_stable", 32'(mem_we), 32'(reqWe));
                if (reqWe) check("bus_wdata_stable", mem_wdata, reqWdata);
            end
            if (stallLeft == 0) begin
                mem_ready = 1'b1;
                if (mem_we) ram[mem_addr] = mem_wdata;
                else mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
                busy = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                stallLeft--;
            end
        end
    end

    function automatic logic [31:0] rIns(int rs, int rt, int rd, int sh, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] iIns(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic pushHalt();
        logic [31:0] here;
        here = RESET_PC + 32'(4 * prog.size());
        prog.push_back({6'h02, here[27:2]});
    endtask

    task automatic loadProgram();
        ram.delete();
        for (int i = 0; i < prog.size(); i++) ram[RESET_PC + 32'(4 * i)] = prog[i];
    endtask

    // Instruction-level reference model.
    logic [31:0] mRegs [32];
    logic [31:0] mPc, mPortOut;
    int          mCount, mCycles;
    bit          mTrap;

    task automatic modelRun();
        logic [31:0] ins, pc4, a, b, simm, addr, res, nextPc;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dest;
        logic [15:0] imm;
        bit          illegal, wrEn;
        int          cyc;
        for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
        mPc = RESET_PC; mPortOut = 32'h0; mCount = 0; mCycles = 0; mTrap = 0;
        refMem = ram;
        for (int step = 0; step < 2000; step++) begin
            ins  = refMem.exists(mPc) ? refMem[mPc] : 32'h0;
            op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            sh   = ins[10:6];  fn = ins[5:0];   imm = ins[15:0];
            a    = mRegs[rs];  b = mRegs[rt];   pc4 = mPc + 32'd4;
            simm = {{16{imm[15]}}, imm};
            if (op == 6'h02 && {pc4[31:28], ins[25:0], 2'b00} == mPc) break;
            illegal = 0; wrEn = 0; dest = rt; nextPc = pc4; cyc = 4; res = 32'h0;
            case (op)
                6'h00: begin
                    dest = rd; wrEn = 1;
                    case (fn)
                        FN_ADD:  res = a + b;
                        FN_SUB:  res = a - b;
                        FN_AND:  res = a & b;
                        FN_OR:   res = a | b;
                        FN_NOR:  res = ~(a | b);
                        FN_SLL:  res = b << sh;
                        FN_SRL:  res = b >> sh;
                        default: illegal = 1;
                    endcase
                end
                OP_ADDI: begin wrEn = 1; res = a + simm; end
                OP_ORI:  begin wrEn = 1; res = a | {16'h0, imm}; end
                OP_LUI:  begin wrEn = 1; res = {imm, 16'h0}; end
                OP_BEQ:  begin cyc = 3; if (a == b) nextPc = pc4 + (simm << 2); end
                OP_BNE:  begin cyc = 3; if (a != b) nextPc = pc4 + (simm << 2); end
                OP_LW: begin
                    cyc = 5; wrEn = 1; addr = a + simm;
                    if (addr == IO_IN) res = {24'h0, portIn};
                    else res = refMem.exists(addr) ? refMem[addr] : 32'h0;
                end
                OP_SW: begin
                    addr = a + simm;
                    if (addr == IO_OUT) mPortOut = b;
                    else refMem[addr] = b;
                end
                6'h02:   begin cyc = 2; nextPc = {pc4[31:28], ins[25:0], 2'b00}; end
                default: illegal = 1;
            endcase
            if (illegal) begin
                mTrap = 1; mCycles += 2; mPc = pc4;
                break;
            end
            if (wrEn && dest != 5'd0) mRegs[dest] = res;
            mPc = nextPc; mCount++; mCycles += cyc;
        end
    endtask

    task automatic applyReset();
        reset = 1'b0;
        #1;
        check("reset_drops_req", 32'(mem_req), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Model the loaded program, run the DUT until the model's retire count (or trap), compare.
    task automatic runProgram(input string name, input int stallMax);
        int cyc;
        bit done;
        modelRun();
        maxStall = stallMax;
        applyReset();
        releaseReset();
        cyc = 0; done = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            done = mTrap ? (trap === 1'b1) : (instr_count == 32'(mCount));
        end
        check({name, ":finished"}, 32'(done), 32'h1);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s:reg%0d", name, i), dut.regFile.regs[i], mRegs[i]);
        check({name, ":instr_count"}, instr_count, 32'(mCount));
        check({name, ":pc"}, pc_out, mPc);
        check({name, ":port_out"}, port_out, mPortOut);
        check({name, ":trap"}, 32'(trap), 32'(mTrap));
        if (stallMax == 0) check({name, ":cycles"}, 32'(cyc - 1), 32'(mCycles));
    endtask

    task automatic genRandomAlu(input int n);
        int rs, rt, rd, sh;
        prog.delete();
        for (int r = 1; r < 8; r++) prog.push_back(iIns(OP_ADDI, 0, r, 16'($urandom)));
        for (int k = 0; k < n; k++) begin
            rs = int'($urandom_range(0, 7)); rt = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 7)); sh = int'($urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0: prog.push_back(rIns(rs, rt, rd, 0, FN_ADD));
                1: prog.push_back(rIns(rs, rt, rd, 0, FN_SUB));
                2: prog.push_back(rIns(rs, rt, rd, 0, FN_AND));
                3: prog.push_back(rIns(rs, rt, rd, 0, FN_OR));
                4: prog.push_back(rIns(rs, rt, rd, 0, FN_NOR));
                5: prog.push_back(rIns(0, rt, rd, sh, FN_SLL));
                6: prog.push_back(rIns(0, rt, rd, sh, FN_SRL));
                7: prog.push_back(iIns(OP_ADDI, rs, rt, 16'($urandom)));
                8: prog.push_back(iIns(OP_ORI, rs, rt, 16'($urandom)));
                default: prog.push_back(iIns(OP_LUI, 0, rt, 16'($urandom)));
            endcase
        end
        pushHalt();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first instruction timing with zero-wait memory.
        prog.delete();
        prog.push_back(iIns(OP_ADDI, 0, 8, 16'd5));
        pushHalt();
        loadProgram();
        maxStall = 0;
        applyReset();
        check("rst_pc", pc_out, RESET_PC);
        check("rst_count", instr_count, 32'h0);
        check("rst_trap", 32'(trap), 32'h0);
        check("rst_port_out", port_out, 32'h0);
        check("rst_alu_out", alu_result_out, 32'h0);
        releaseReset();
        @(negedge clk);
        check("first_req", 32'(mem_req), 32'h1);
        check("first_we", 32'(mem_we), 32'h0);
        check("first_addr", mem_addr, RESET_PC);
        repeat (4) @(negedge clk);
        check("first_t0", dut.regFile.regs[8], 32'd5);
        check("first_count", instr_count, 32'd1);
        check("first_pc", pc_out, RESET_PC + 32'd4);
        check("first_alu_out", alu_result_out, 32'd5);

        // Random ALU sequences: one zero-wait (cycle-exact), three with 0..3 stalls.
        for (int p = 0; p < 4; p++) begin
            genRandomAlu(24);
            loadProgram();
            runProgram($sformatf("alu%0d", p), (p == 0) ? 0 : 3);
        end

        // Branches: beq taken/not taken, bne loop, beq offset -2.
        prog.delete();
        prog.push_back(iIns(OP_ADDI, 0, 2, 16'd7));
        prog.push_back(iIns(OP_ADDI, 0, 3, 16'd7));
        prog.push_back(iIns(OP_ADDI, 0, 7, 16'd1));
        prog.push_back(iIns(OP_BEQ, 2, 3, 16'h0001));
        prog.push_back(iIns(OP_ADDI, 0, 4, 16'd1));
        prog.push_back(iIns(OP_BEQ, 2, 0, 16'h0001));
        prog.push_back(iIns(OP_ADDI, 0, 5, 16'd9));
        prog.push_back(iIns(OP_ADDI, 0, 1, 16'd2));
        prog.push_back(iIns(OP_ADDI, 1, 1, 16'hFFFF));
        prog.push_back(iIns(OP_BNE, 1, 0, 16'hFFFE));
        prog.push_back(iIns(OP_ADDI, 6, 6, 16'd1));
        prog.push_back(iIns(OP_BEQ, 6, 7, 16'hFFFE));
        pushHalt();
        loadProgram();
        runProgram("branch", 0);
        check("branch_skipped", dut.regFile.regs[4], 32'd0);
        check("branch_fallthru", dut.regFile.regs[5], 32'd9);
        check("branch_beq_loop", dut.regFile.regs[6], 32'd2);
        check("branch_retired", instr_count, 32'd15);
        check("branch_halt_pc", pc_out, RESET_PC + 32'd48);

        // Memory-mapped I/O: neither access may reach the bus.
        prog.delete();
        prog.push_back(iIns(OP_LUI, 0, 9, 16'h1001));
        prog.push_back(iIns(OP_ADDI, 0, 8, 16'h00A5));
        prog.push_back(iIns(OP_SW, 9, 8, 16'h0024));
        prog.push_back(iIns(OP_LW, 9, 10, 16'h0028));
        pushHalt();
        loadProgram();
        portIn = 8'h3C;
        ioBusHits = 0;
        runProgram("io", 2);
        check("io_port_out", port_out, 32'h0000_00A5);
        check("io_port_in", dut.regFile.regs[10], 32'h0000_003C);
        check("io_no_bus", 32'(ioBusHits), 32'h0);

        // RAM round trip, $0 writes discarded, crossed I/O directions go to the bus.
        prog.delete();
        prog.push_back(iIns(OP_LUI, 0, 9, 16'h1001));
        prog.push_back(iIns(OP_ADDI, 0, 8, 16'hFB2E));
        prog.push_back(iIns(OP_SW, 9, 8, 16'h0000));
        prog.push_back(iIns(OP_LW, 9, 11, 16'h0000));
        prog.push_back(iIns(OP_LW, 9, 0, 16'h0000));
        prog.push_back(iIns(OP_ADDI, 0, 0, 16'd7));
        prog.push_back(iIns(OP_LW, 9, 12, 16'h0024));
        prog.push_back(iIns(OP_SW, 9, 8, 16'h0028));
        pushHalt();
        loadProgram();
        ram[IO_OUT] = 32'h1234_5678;
        portIn = 8'h5E;
        runProgram("ram", 3);
        check("ram_roundtrip", dut.regFile.regs[11], 32'hFFFF_FB2E);
        check("ram_zero_reg", dut.regFile.regs[0], 32'h0);
        check("ram_bus_read_ioout", dut.regFile.regs[12], 32'h1234_5678);
        check("ram_word", ram[RAM_BASE], refMem[RAM_BASE]);
        check("ram_bus_write_ioin", ram[IO_IN], 32'hFFFF_FB2E);

        // Illegal opcode and illegal funct both trap and stay quiet until reset.
        for (int t = 0; t < 2; t++) begin
            prog.delete();
            prog.push_back(iIns(OP_ADDI, 0, 8, 16'd5));
            prog.push_back((t == 0) ? 32'hFC00_0000 : rIns(8, 8, 9, 0, 6'h21));
            pushHalt();
            loadProgram();
            runProgram($sformatf("trap%0d", t), 0);
            check("trap_pc", pc_out, RESET_PC + 32'd8);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("trap_no_req", 32'(mem_req), 32'h0);
                check("trap_sticky", 32'(trap), 32'h1);
            end
            reset = 1'b0;
            #1;
            check("trap_cleared", 32'(trap), 32'h0);
            check("trap_reset_pc", pc_out, RESET_PC);
            check("trap_reset_count", instr_count, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
